// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, display enable,
// line/frame strobes and a free-running completed-frame counter.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY        = 640,
  parameter int unsigned H_FRONT          = 16,
  parameter int unsigned H_SYNC           = 96,
  parameter int unsigned H_BACK           = 48,
  parameter int unsigned V_DISPLAY        = 480,
  parameter int unsigned V_FRONT          = 10,
  parameter int unsigned V_SYNC           = 2,
  parameter int unsigned V_BACK           = 33,
  parameter int unsigned SYNC_ACTIVE_HIGH = 0,
  parameter int unsigned FRAME_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_hold,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_end,
  output logic               frame_end,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SS    = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SE    = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int unsigned V_SS    = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SE    = V_DISPLAY + V_FRONT + V_SYNC;
  localparam logic        SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

  logic [CNT_W-1:0]   hpos_q, hpos_d;
  logic [CNT_W-1:0]   vpos_q, vpos_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               last_pix, last_line;
  logic               h_in_sync, v_in_sync, in_display;

  // Position decode; everything here is zero-latency relative to the counters.
  always_comb begin
    last_pix   = (hpos_q == CNT_W'(H_TOTAL - 1));
    last_line  = (vpos_q == CNT_W'(V_TOTAL - 1));
    h_in_sync  = (hpos_q >= CNT_W'(H_SS)) && (hpos_q < CNT_W'(H_SE));
    v_in_sync  = (vpos_q >= CNT_W'(V_SS)) && (vpos_q < CNT_W'(V_SE));
    in_display = (hpos_q < CNT_W'(H_DISPLAY)) && (vpos_q < CNT_W'(V_DISPLAY));
  end

  // Next-state: hpos every clock, vpos on the last pixel, frame_count on frame end.
  always_comb begin
    hpos_d        = hpos_q + CNT_W'(1);
    vpos_d        = vpos_q;
    frame_count_d = frame_count_q;
    if (last_pix) begin
      hpos_d = '0;
      vpos_d = last_line ? '0 : vpos_q + CNT_W'(1);
      if (last_line && !frame_hold) begin
        frame_count_d = frame_count_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_count_q <= '0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Strobes and syncs are forced inactive for as long as reset is held.
  always_comb begin
    hpos        = hpos_q;
    vpos        = vpos_q;
    frame_count = frame_count_q;
    display_on  = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;
    hsync       = ~SYNC_ON;
    vsync       = ~SYNC_ON;
    if (!reset) begin
      display_on = in_display;
      line_end   = last_pix;
      frame_end  = last_pix && last_line;
      hsync      = h_in_sync ? SYNC_ON : ~SYNC_ON;
      vsync      = v_in_sync ? SYNC_ON : ~SYNC_ON;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size active-low instance for line timing and a
// shrunken active-high instance for frame, hold, wrap and reset behaviour.
module tb_vga_sync_gen;

  // Full-size instance A
  localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VD = 480, A_VF = 10, A_VS = 2, A_VB = 33;
  localparam int A_HT = A_HD + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VD + A_VF + A_VS + A_VB;
  // Small instance B: 15 x 11 raster, 3-bit frame counter
  localparam int B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VD = 6, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_HT = B_HD + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VD + B_VF + B_VS + B_VB;
  localparam int B_FR = B_HT * B_VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_hold = 1'b0;

  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
  logic a_hsync, a_vsync, a_de, a_le, a_fe;
  logic b_hsync, b_vsync, b_de, b_le, b_fe;
  logic [7:0] a_fc;
  logic [2:0] b_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_a (
    .clk(clk), .reset(reset), .frame_hold(frame_hold),
    .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hsync), .vsync(a_vsync),
    .display_on(a_de), .line_end(a_le), .frame_end(a_fe), .frame_count(a_fc)
  );

  vga_sync_gen #(
    .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .SYNC_ACTIVE_HIGH(1), .FRAME_W(3)
  ) u_b (
    .clk(clk), .reset(reset), .frame_hold(frame_hold),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
    .display_on(b_de), .line_end(b_le), .frame_end(b_fe), .frame_count(b_fc)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position is just the count of clocks since reset, modulo the frame size.
  int  ta = 0, tb = 0, fa = 0, fb = 0;
  bit  mvalid = 0;
  int  eh, ev;

  always @(posedge clk) begin
    if (reset) begin
      ta = 0; tb = 0; fa = 0; fb = 0; mvalid = 1;
    end else if (mvalid) begin
      if (ta == A_HT * A_VT - 1) begin
        if (!frame_hold) fa = (fa + 1) % 256;
        ta = 0;
      end else ta++;
      if (tb == B_FR - 1) begin
        if (!frame_hold) fb = (fb + 1) % 8;
        tb = 0;
      end else tb++;
    end
    #1;
    if (mvalid) begin
      eh = ta % A_HT; ev = ta / A_HT;
      check("a_hpos", a_hpos, eh);
      check("a_vpos", a_vpos, ev);
      check("a_fc", a_fc, fa);
      check("a_de", a_de, (!reset && eh < A_HD && ev < A_VD));
      check("a_le", a_le, (!reset && eh == A_HT - 1));
      check("a_fe", a_fe, (!reset && eh == A_HT - 1 && ev == A_VT - 1));
      check("a_hsync", a_hsync, !(!reset && eh >= A_HD + A_HF && eh < A_HD + A_HF + A_HS));
      check("a_vsync", a_vsync, !(!reset && ev >= A_VD + A_VF && ev < A_VD + A_VF + A_VS));
      eh = tb % B_HT; ev = tb / B_HT;
      check("b_hpos", b_hpos, eh);
      check("b_vpos", b_vpos, ev);
      check("b_fc", b_fc, fb);
      check("b_de", b_de, (!reset && eh < B_HD && ev < B_VD));
      check("b_le", b_le, (!reset && eh == B_HT - 1));
      check("b_fe", b_fe, (!reset && eh == B_HT - 1 && ev == B_VT - 1));
      check("b_hsync", b_hsync, (!reset && eh >= B_HD + B_HF && eh < B_HD + B_HF + B_HS));
      check("b_vsync", b_vsync, (!reset && ev >= B_VD + B_VF && ev < B_VD + B_VF + B_VS));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset for 5 clocks; forced outputs while held
    step(5);
    #1;
    check("rst_a_de", a_de, 0);
    check("rst_a_hsync", a_hsync, 1);
    check("rst_a_vsync", a_vsync, 1);
    check("rst_b_hsync", b_hsync, 0);
    check("rst_b_vsync", b_vsync, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("lit_first_hpos", a_hpos, 0);
    check("lit_first_vpos", a_vpos, 0);
    check("lit_first_de", a_de, 1);
    check("lit_first_hsync", a_hsync, 1);
    check("lit_first_fc", a_fc, 0);

    // Line timing on the full-size instance
    step(639); #1;
    check("lit_de_639", a_de, 1);
    step(1); #1;
    check("lit_de_640", a_de, 0);
    step(16); #1;
    check("lit_hpos_656", a_hpos, 656);
    check("lit_hsync_656", a_hsync, 0);
    step(95); #1;
    check("lit_hsync_751", a_hsync, 0);
    step(1); #1;
    check("lit_hsync_752", a_hsync, 1);
    step(47); #1;
    check("lit_le_799", a_le, 1);
    step(1); #1;
    check("lit_vpos_800", a_vpos, 1);
    check("lit_hpos_800", a_hpos, 0);

    // Frame hold on the small instance
    do_reset(1);
    step(2 * B_FR); #1;
    check("lit_fc_2", b_fc, 2);
    frame_hold = 1'b1;
    step(B_FR); #1;
    check("lit_fc_hold", b_fc, 2);
    frame_hold = 1'b0;
    step(B_FR - 20); #1;
    frame_hold = 1'b1;
    step(5);
    frame_hold = 1'b0;
    step(15); #1;
    check("lit_fc_3", b_fc, 3);

    // Counter wrap: eight frames from reset return to zero
    do_reset(1);
    step(8 * B_FR); #1;
    check("lit_fc_wrap", b_fc, 0);
    step(B_FR); #1;
    check("lit_fc_after_wrap", b_fc, 1);

    // Mid-frame single-clock reset
    do_reset(1);
    step(4 * B_HT + 5); #1;
    check("lit_mid_hpos", b_hpos, 5);
    check("lit_mid_vpos", b_vpos, 4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("lit_mid_rst_le", b_le, 0);
    check("lit_mid_rst_de", b_de, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("lit_mid_hpos0", b_hpos, 0);
    check("lit_mid_vpos0", b_vpos, 0);
    check("lit_mid_fc0", b_fc, 0);

    // Randomized hold toggling with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      frame_hold = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    frame_hold = 1'b0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
